// File: rtl/seq_divider_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_divider_pkg: shared states and constants for the sequential divider  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } div_state_e;

  localparam int DEFAULT_WIDTH = 16;
  localparam int CNT_W = $clog2(DEFAULT_WIDTH);

  // Replicated across the quotient width on a zero divisor.
  localparam logic DIVZ_QUOTIENT_BIT = 1'b1;

endpackage : seq_divider_pkg
`default_nettype wire

// File: rtl/div_trial_sub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_trial_sub: (WIDTH+1)-bit trial subtractor A + ~B + 1, 4-bit CLA      |
// | groups rippling between groups. Revision: 1.0                            |
// +--------------------------------------------------------------------------+
module div_trial_sub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0] i_a,
  input  logic [WIDTH:0] i_b,
  output logic [WIDTH:0] o_diff,
  output logic           o_nonneg
);

  localparam int c_groups = WIDTH / 4 + 1;
  localparam int c_ext    = c_groups * 4;

  logic [c_ext-1:0]    w_a_ext;
  logic [c_ext-1:0]    w_b_inv;
  logic [c_ext-1:0]    w_sum;
  logic [c_groups:0]   w_gc;
  logic [c_ext-WIDTH-2:0] w_unused_sum_msbs;

  // Zero-extending both operands keeps the final carry equal to (A >= B).
  assign w_a_ext = {{(c_ext-WIDTH-1){1'b0}}, i_a};
  assign w_b_inv = ~{{(c_ext-WIDTH-1){1'b0}}, i_b};
  assign w_gc[0] = 1'b1;

  for (genvar gi = 0; gi < c_groups; gi++) begin : g_grp
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = w_a_ext[gi*4 +: 4] & w_b_inv[gi*4 +: 4];
    assign w_p = w_a_ext[gi*4 +: 4] ^ w_b_inv[gi*4 +: 4];
    assign w_c[0] = w_gc[gi];
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_sum[gi*4 +: 4] = w_p ^ w_c[3:0];
    assign w_gc[gi+1] = w_c[4];
  end

  assign o_diff            = w_sum[WIDTH:0];
  assign o_nonneg          = w_gc[c_groups];
  assign w_unused_sum_msbs = w_sum[c_ext-1:WIDTH+1];

endmodule : div_trial_sub
`default_nettype wire

// File: rtl/seq_divider_16bit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_divider_16bit: restoring divider, one quotient bit per clock.        |
// | Optional DIV_SIGNED_EN adds truncating two's-complement mode. Rev: 1.0   |
// +--------------------------------------------------------------------------+
module seq_divider_16bit
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_signed,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int         c_cnt_w  = $clog2(WIDTH);
  localparam logic [1:0] c_idle   = IDLE;
  localparam logic [1:0] c_calc   = CALC;
  localparam logic [1:0] c_finish = FINISH;

  logic [1:0]         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_dvs;
  logic               r_dz;

  logic [WIDTH:0]     w_rshift;
  logic [WIDTH:0]     w_diff;
  logic               w_nonneg;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_q_final;
  logic [WIDTH-1:0]   w_r_final;
  logic               w_divisor_zero;
  logic               w_unused_diff_msb;

  // The dividend register doubles as the quotient shift register.
  assign w_rshift   = {r_rem, r_dvd[WIDTH-1]};
  assign w_rem_next = w_nonneg ? w_diff[WIDTH-1:0] : w_rshift[WIDTH-1:0];
  assign w_quo_next = {r_dvd[WIDTH-2:0], w_nonneg};
  assign w_unused_diff_msb = w_diff[WIDTH];
  assign w_divisor_zero    = (i_divisor == '0);

  div_trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
    .i_a      (w_rshift),
    .i_b      ({1'b0, r_dvs}),
    .o_diff   (w_diff),
    .o_nonneg (w_nonneg)
  );

`ifdef DIV_SIGNED_EN
  logic w_a_neg;
  logic w_b_neg;
  logic r_neg_q;
  logic r_neg_r;

  assign w_a_neg   = i_signed & i_dividend[WIDTH-1];
  assign w_b_neg   = i_signed & i_divisor[WIDTH-1];
  assign w_a_mag   = w_a_neg ? -i_dividend : i_dividend;
  assign w_b_mag   = w_b_neg ? -i_divisor : i_divisor;
  assign w_q_final = r_neg_q ? -w_quo_next : w_quo_next;
  assign w_r_final = r_neg_r ? -w_rem_next : w_rem_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == c_idle && i_start) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end
  end
`else
  logic w_unused_signed;

  assign w_unused_signed = i_signed;
  assign w_a_mag   = i_dividend;
  assign w_b_mag   = i_divisor;
  assign w_q_final = w_quo_next;
  assign w_r_final = w_rem_next;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= c_idle;
      r_cnt         <= '0;
      r_rem         <= '0;
      r_dvd         <= '0;
      r_dvs         <= '0;
      r_dz          <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (i_start) begin
            // Zero divisor keeps the raw dividend and spends one CALC cycle so DONE lands one clock after accept.
            r_dvd   <= w_divisor_zero ? i_dividend : w_a_mag;
            r_dvs   <= w_b_mag;
            r_rem   <= '0;
            r_dz    <= w_divisor_zero;
            r_cnt   <= w_divisor_zero ? '0 : c_cnt_w'(WIDTH - 1);
            r_state <= c_calc;
          end
        end
        c_calc: begin
          if (r_dz) begin
            o_quotient    <= {WIDTH{DIVZ_QUOTIENT_BIT}};
            o_remainder   <= r_dvd;
            o_div_by_zero <= 1'b1;
            r_state       <= c_finish;
          end else begin
            r_rem <= w_rem_next;
            r_dvd <= w_quo_next;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
              o_quotient    <= w_q_final;
              o_remainder   <= w_r_final;
              o_div_by_zero <= 1'b0;
              r_state       <= c_finish;
            end
          end
        end
        c_finish: r_state <= c_idle;
        default:  r_state <= c_idle;
      endcase
    end
  end

  assign o_busy = (r_state != c_idle);
  assign o_done = (r_state == c_finish);

endmodule : seq_divider_16bit
`default_nettype wire

// File: tb/tb_seq_divider_16bit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seq_divider_16bit: randomized self-checking bench for the divider     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_seq_divider_16bit;

`ifdef DIV_SIGNED_EN
  localparam bit c_signed_build = 1'b1;
`else
  localparam bit c_signed_build = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        sgn = 1'b0;
  logic        busy, done, dbz;
  logic [15:0] quo, rem;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_divider_16bit #(.WIDTH(16)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .i_signed      (sgn),
    .o_busy        (busy),
    .o_done        (done),
    .o_quotient    (quo),
    .o_remainder   (rem),
    .o_div_by_zero (dbz)
  );

  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                output logic [15:0] q, output logic [15:0] r, output logic z);
    int sa, sb;
    if (b == 16'h0) begin
      q = 16'hFFFF; r = a; z = 1'b1;
    end else if (s && c_signed_build) begin
      sa = int'($signed(a)); sb = int'($signed(b));
      q = 16'(sa / sb); r = 16'(sa % sb); z = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  // Issues one operation, returns results and START-to-DONE latency in clocks.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        output int lat, output logic [15:0] q, output logic [15:0] r,
                        output logic z, output logic single);
    @(negedge clk);
    dividend = a; divisor = b; sgn = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    q = quo; r = rem; z = dbz;
    @(posedge clk); #1;
    single = !done && !busy;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, quo, rem, dbz} !== 35'h0) begin
      errors++;
      $display("FAIL reset_state got %b/%b/%h/%h/%b exp all zero", busy, done, quo, rem, dbz);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] a_t [4] = '{16'd100, 16'hFFFF, 16'h0005, 16'h1234};
    logic [15:0] b_t [4] = '{16'd7,   16'h0001, 16'h0009, 16'h0000};
    logic [15:0] eq_t[4] = '{16'd14,  16'hFFFF, 16'h0000, 16'hFFFF};
    logic [15:0] er_t[4] = '{16'd2,   16'h0000, 16'h0005, 16'h1234};
    int          el_t[4] = '{16, 16, 16, 1};
    int lat; logic [15:0] q, r; logic z, single;
    for (int i = 0; i < 4; i++) begin
      run_op(a_t[i], b_t[i], 1'b0, lat, q, r, z, single);
      checks++;
      if (q !== eq_t[i] || r !== er_t[i] || z !== (b_t[i] == 0)) begin
        errors++;
        $display("FAIL directed_%0d got q=%h r=%h z=%b exp q=%h r=%h z=%b",
                 i, q, r, z, eq_t[i], er_t[i], b_t[i] == 0);
      end
      checks++;
      if (lat !== el_t[i] || !single) begin
        errors++;
        $display("FAIL directed_timing_%0d got lat=%0d single=%b exp lat=%0d single=1",
                 i, lat, single, el_t[i]);
      end
    end
  endtask

  task automatic test_signed_mode();
    logic [15:0] q, r, eq, er; logic z, ez, single; int lat;
    logic [15:0] a_t[3] = '{16'hFFF9, 16'h8000, 16'hFFF9};
    logic [15:0] b_t[3] = '{16'h0002, 16'hFFFF, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      run_op(a_t[i], b_t[i], 1'b1, lat, q, r, z, single);
      model(a_t[i], b_t[i], 1'b1, eq, er, ez);
      checks++;
      if (q !== eq || r !== er || z !== ez || lat !== (b_t[i] == 0 ? 1 : 16)) begin
        errors++;
        $display("FAIL signed_%0d got q=%h r=%h z=%b lat=%0d exp q=%h r=%h z=%b",
                 i, q, r, z, lat, eq, er, ez);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] prev_q, prev_r;
    int lat;
    prev_q = quo; prev_r = rem;
    @(negedge clk);
    dividend = 16'd100; divisor = 16'd7; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
    @(negedge clk);
    dividend = 16'd999; divisor = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = 16'd0; divisor = 16'd0;
    checks++;
    if (quo !== prev_q || rem !== prev_r || !busy || done) begin
      errors++;
      $display("FAIL hold_prev got q=%h r=%h busy=%b exp q=%h r=%h busy=1", quo, rem, busy, prev_q, prev_r);
    end
    lat = 5;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if (quo !== 16'd14 || rem !== 16'd2 || lat !== 16) begin
      errors++;
      $display("FAIL busy_ignore got q=%0d r=%0d lat=%0d exp q=14 r=2 lat=16", quo, rem, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat, seen; logic [15:0] q, r; logic z, single;
    @(negedge clk);
    dividend = 16'd100; divisor = 16'd7; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quo, rem, dbz} !== 35'h0) begin
      errors++;
      $display("FAIL reset_mid got %b/%b/%h/%h/%b exp all zero", busy, done, quo, rem, dbz);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (done || busy) seen++; end
    @(negedge clk); rst_n = 1'b1;
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_no_done got %0d active cycles exp 0", seen);
    end
    run_op(16'd100, 16'd7, 1'b0, lat, q, r, z, single);
    checks++;
    if (q !== 16'd14 || r !== 16'd2 || z !== 1'b0 || lat !== 16 || !single) begin
      errors++;
      $display("FAIL after_reset got q=%0d r=%0d z=%b lat=%0d exp q=14 r=2 z=0 lat=16", q, r, z, lat);
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, q, r, eq, er; logic s, z, ez, single; int lat;
    for (int n = 0; n < 60; n++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 16'h0;
        1: b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      s = 1'($urandom);
      run_op(a, b, s, lat, q, r, z, single);
      model(a, b, s, eq, er, ez);
      checks++;
      if (q !== eq || r !== er || z !== ez || lat !== (b == 0 ? 1 : 16) || !single) begin
        errors++;
        $display("FAIL random_%0d %h/%h s=%b got q=%h r=%h z=%b lat=%0d exp q=%h r=%h z=%b",
                 n, a, b, s, q, r, z, lat, eq, er, ez);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_signed_mode();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seq_divider_16bit
`default_nettype wire

// File: doc/seq_divider_16bit.md
# seq_divider_16bit

Multi-cycle restoring integer divider for the 16-bit ALU datapath. It produces the quotient and remainder of two 16-bit operands by repeated trial subtraction, one quotient bit per clock. It sits beside the carry-lookahead adder/subtractor slice and is started and collected by the ALU control through a start/done handshake.

## Interface
- WIDTH, 16, operand/result width in bits (must be a multiple of 4)
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- START  input  1  request; accepted only when BUSY=0
- DIVIDEND  input  WIDTH  numerator, sampled on accept
- DIVISOR  input  WIDTH  denominator, sampled on accept
- SIGNED  input  1  two's-complement mode, sampled on accept (ignored unless macro enabled)
- BUSY  output  1  high from accept until DONE cycle ends
- DONE  output  1  one-cycle pulse: results valid
- QUOTIENT  output  WIDTH  result quotient, held until next DONE
- REMAINDER  output  WIDTH  result remainder, held until next DONE
- DIV_BY_ZERO  output  1  flag for last result, held until next DONE

## Operation
- States: IDLE, CALC, FINISH. Reset enters IDLE and clears every output and internal register to 0.
- IDLE: START=1 captures operands and SIGNED. If DIVISOR==0 -> FINISH; else -> CALC with step counter = WIDTH-1.
- CALC: partial remainder R is WIDTH+1 bits. Each cycle: R' = {R[WIDTH-1:0], dividend MSB}, dividend shifted left; trial T = R' - D (WIDTH+1-bit, computed as R' + ~D + 1). T non-negative -> R = T, shift in quotient bit 1; else R = R', shift in 0. Counter reaches 0 -> FINISH.
- FINISH: QUOTIENT/REMAINDER/DIV_BY_ZERO registers load; DONE=1 for this single cycle; -> IDLE.
- Divide by zero: QUOTIENT = all ones, REMAINDER = DIVIDEND as captured, DIV_BY_ZERO=1. Otherwise DIV_BY_ZERO=0.
- START while BUSY=1 (CALC or FINISH): ignored, no effect on operands or result.
- Result registers change only on FINISH entry; previous result stays stable during a new computation.
- Reset asserted mid-CALC: immediate return to IDLE, all outputs 0, no DONE pulse.

## Timing
- Accept at edge E0. Nonzero divisor: CALC iterations at E1..E16; FINISH entered at E16; DONE high E16–E17; results visible from E16. Latency 16 cycles START-to-DONE (WIDTH in general).
- Zero divisor: FINISH at E1; DONE high E1–E2.
- BUSY rises at E0, falls at E17 (E2 for divide-by-zero); earliest next accept at E17.
- No combinational path from inputs to outputs.

## Configuration
- DIV_SIGNED_EN defined: SIGNED=1 divides magnitudes, quotient negated if operand signs differ, remainder takes dividend sign (truncating division). Corrections applied at FINISH load; latency unchanged. Most-negative / -1 yields QUOTIENT=0x8000, REMAINDER=0. Divide by zero as unsigned rule (all ones, dividend unchanged).
- Undefined: SIGNED input ignored; all operands unsigned; no sign/negation logic synthesized.

## Structure
- Package seq_divider_pkg: state enum (IDLE, CALC, FINISH), default WIDTH, counter width constant, divide-by-zero quotient constant.
- One sub-module: div_trial_sub, WIDTH+1-bit subtractor (A + ~B + 1) built from 4-bit carry-lookahead groups, outputs difference and non-negative flag.

## Test plan
- Unsigned 100 / 7 -> QUOTIENT=14, REMAINDER=2, DIV_BY_ZERO=0, DONE exactly 16 cycles after accept, single-cycle pulse.
- 0xFFFF / 0x0001 -> QUOTIENT=0xFFFF, REMAINDER=0; 0x0005 / 0x0009 -> QUOTIENT=0, REMAINDER=5.
- 0x1234 / 0 -> DONE 1 cycle after accept, QUOTIENT=0xFFFF, REMAINDER=0x1234, DIV_BY_ZERO=1.
- DIV_SIGNED_EN, SIGNED=1: -7 / 2 -> QUOTIENT=0xFFFD, REMAINDER=0xFFFF; 0x8000 / 0xFFFF -> QUOTIENT=0x8000, REMAINDER=0.
- Second START with different operands at E5 of a 100/7 run -> ignored; result still 14/2.
- RST_N low at E8 of a run -> all outputs 0 at once, BUSY=0, no DONE; new 100/7 after release completes normally.
